// File: rtl/exec_pipe_pkg.sv
// Shared types for the registered execute stage: op codes, FSM states,
// branch condition encodings and the condition evaluator.
package exec_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_XOR   = 4'd4,
    OP_SLL   = 4'd5,
    OP_SRL   = 4'd6,
    OP_PASSB = 4'd7,
    OP_SEQ   = 4'd8,
    OP_SLT   = 4'd9,
    OP_MUL   = 4'd10
  } exec_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL_BUSY,
    ST_MUL_DONE
  } exec_state_e;

  localparam logic [1:0] BC_EQZ = 2'b00;
  localparam logic [1:0] BC_NEZ = 2'b01;
  localparam logic [1:0] BC_LTZ = 2'b10;
  localparam logic [1:0] BC_GEZ = 2'b11;

  // Signed tests on Rs only need its zero flag and sign bit.
  function automatic logic branch_cond(input logic [1:0] cont, input logic is_zero,
                                       input logic is_neg);
    case (cont)
      BC_EQZ:  return is_zero;
      BC_NEZ:  return !is_zero;
      BC_LTZ:  return is_neg;
      default: return !is_neg;
    endcase
  endfunction

endpackage

// File: rtl/exec_pipe_mul_iter.sv
// Iterative shift-add multiplier: one partial-product step per cycle,
// WIDTH steps per operation, low WIDTH bits of the product kept.
module mul_iter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    cnt;

  // done marks the cycle whose closing edge performs the final step.
  assign done    = busy && (cnt == '0);
  assign product = acc;

  // NOTE: sequential state is assigned with <= so every register samples
  // pre-edge values; blocking = here would make the order of statements matter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy   <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (abort) begin
      busy <= 1'b0;
      acc  <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      cnt    <= CW'(WIDTH - 1);
      acc    <= '0;
      mcand  <= a;
      mplier <= b;
    end else if (busy) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - 1'b1;
      if (cnt == '0) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/exec_pipe.sv
// Registered execute stage with valid/ready on both sides and branch resolution.
// Define EXEC_MUL_EN to build the iterative multiplier and its MUL_BUSY/MUL_DONE states.
module exec_pipe
  import exec_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  input  logic [WIDTH-1:0] data_1,
  input  logic [WIDTH-1:0] data_2,
  input  logic [WIDTH-1:0] ext_out,
  input  logic [WIDTH-1:0] seq_PC,
  input  logic             choose_branch,
  input  logic             immed,
  input  logic             update_R7,
  input  logic [3:0]       op,
  input  logic [1:0]       branch_cont,
  input  logic             branch_I,
  input  logic             branch_J,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALU_out,
  output logic [WIDTH-1:0] data_2_out,
  output logic [WIDTH-1:0] branch_PC,
  output logic             branch
);

  localparam int SHW = $clog2(WIDTH);

  logic [WIDTH-1:0] b_opnd;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] bpc_res;
  logic             br_res;
  logic             accept;
  logic             load_out;
  logic [WIDTH-1:0] alu_next;
  logic [WIDTH-1:0] d2_next;
  logic [WIDTH-1:0] bpc_next;
  logic             br_next;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    b_opnd  = update_R7 ? seq_PC : (immed ? ext_out : data_2);
    alu_res = '0;
    case (op)
      OP_ADD:   alu_res = data_1 + b_opnd;
      OP_SUB:   alu_res = data_1 - b_opnd;
      OP_AND:   alu_res = data_1 & b_opnd;
      OP_OR:    alu_res = data_1 | b_opnd;
      OP_XOR:   alu_res = data_1 ^ b_opnd;
      OP_SLL:   alu_res = data_1 << b_opnd[SHW-1:0];
      OP_SRL:   alu_res = data_1 >> b_opnd[SHW-1:0];
      OP_PASSB: alu_res = b_opnd;
      OP_SEQ:   alu_res = {{(WIDTH-1){1'b0}}, data_1 == b_opnd};
      OP_SLT:   alu_res = {{(WIDTH-1){1'b0}}, $signed(data_1) < $signed(b_opnd)};
      default:  alu_res = '0;
    endcase
  end

  assign bpc_res = ext_out + (choose_branch ? data_1 : seq_PC);
  assign br_res  = (branch_I & branch_cond(branch_cont, data_1 == '0, data_1[WIDTH-1]))
                 | branch_J;

`ifdef EXEC_MUL_EN
  exec_state_e      state;
  logic             start_mul;
  logic             mul_load;
  logic             mul_busy;
  logic             mul_done;
  logic [WIDTH-1:0] mul_prod;
  logic [WIDTH-1:0] hold_d2;
  logic [WIDTH-1:0] hold_bpc;
  logic             hold_br;

  assign in_ready  = (state == ST_IDLE) && !flush && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign start_mul = accept && (op == OP_MUL);
  assign mul_load  = (state == ST_MUL_DONE) && !flush && (!out_valid || out_ready);
  assign load_out  = (accept && (op != OP_MUL)) || mul_load;

  // A finishing MUL presents the side fields captured when it was accepted.
  assign alu_next = mul_load ? mul_prod : alu_res;
  assign d2_next  = mul_load ? hold_d2  : data_2;
  assign bpc_next = mul_load ? hold_bpc : bpc_res;
  assign br_next  = mul_load ? hold_br  : br_res;

  mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (start_mul),
    .abort   (flush),
    .a       (data_1),
    .b       (b_opnd),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_prod)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      hold_d2  <= '0;
      hold_bpc <= '0;
      hold_br  <= 1'b0;
    end else if (flush) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (start_mul) begin
          state    <= ST_MUL_BUSY;
          hold_d2  <= data_2;
          hold_bpc <= bpc_res;
          hold_br  <= br_res;
        end
        ST_MUL_BUSY: begin
          if (mul_done)      state <= ST_MUL_DONE;
          else if (!mul_busy) state <= ST_IDLE;
        end
        ST_MUL_DONE: if (mul_load) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end
`else
  assign in_ready = !flush && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign load_out = accept;
  assign alu_next = alu_res;
  assign d2_next  = data_2;
  assign bpc_next = bpc_res;
  assign br_next  = br_res;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      ALU_out    <= '0;
      data_2_out <= '0;
      branch_PC  <= '0;
      branch     <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (load_out) begin
      out_valid  <= 1'b1;
      ALU_out    <= alu_next;
      data_2_out <= d2_next;
      branch_PC  <= bpc_next;
      branch     <= br_next;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_exec_pipe.sv
// Scoreboard bench for exec_pipe: the driver queues hand-computed results,
// a monitor pops and compares on every output handshake.
module tb_exec_pipe;
  import exec_pkg::*;

  localparam int W = 16;
`ifdef EXEC_MUL_EN
  localparam int          MUL_LOW = W + 1;
  localparam bit          MUL_ON  = 1'b1;
  localparam logic [15:0] MUL_EXP = 16'h03A8;
`else
  localparam int          MUL_LOW = 0;
  localparam bit          MUL_ON  = 1'b0;
  localparam logic [15:0] MUL_EXP = 16'h0000;
`endif

  typedef struct {
    logic [W-1:0] alu;
    logic [W-1:0] d2;
    logic [W-1:0] bpc;
    logic         br;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         flush = 1'b0;
  logic [W-1:0] data_1 = '0, data_2 = '0, ext_out = '0, seq_PC = '0;
  logic         choose_branch = 1'b0, immed = 1'b0, update_R7 = 1'b0;
  logic [3:0]   op = '0;
  logic [1:0]   branch_cont = '0;
  logic         branch_I = 1'b0, branch_J = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] ALU_out, data_2_out, branch_PC;
  logic         branch;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   waited;
  int   burst_waits;
  int   low_cycles;

  exec_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .data_1(data_1), .data_2(data_2), .ext_out(ext_out), .seq_PC(seq_PC),
    .choose_branch(choose_branch), .immed(immed), .update_R7(update_R7), .op(op),
    .branch_cont(branch_cont), .branch_I(branch_I), .branch_J(branch_J),
    .out_valid(out_valid), .out_ready(out_ready), .ALU_out(ALU_out),
    .data_2_out(data_2_out), .branch_PC(branch_PC), .branch(branch)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Present one op, hold it until accepted (bounded), optionally queue its result.
  task automatic issue(input logic [3:0] o, input logic [W-1:0] d1, input logic [W-1:0] d2,
                       input logic [W-1:0] ext, input logic [W-1:0] seq,
                       input logic cb, input logic im, input logic r7, input logic [1:0] bc,
                       input logic bi, input logic bj, input logic [W-1:0] e_alu,
                       input logic [W-1:0] e_bpc, input logic e_br, input bit push,
                       output int wait_cycles);
    exp_t e;
    op = o; data_1 = d1; data_2 = d2; ext_out = ext; seq_PC = seq;
    choose_branch = cb; immed = im; update_R7 = r7; branch_cont = bc;
    branch_I = bi; branch_J = bj; in_valid = 1'b1;
    wait_cycles = 0;
    @(negedge clk);
    while (!in_ready && wait_cycles < 200) begin
      wait_cycles++;
      @(negedge clk);
    end
    if (!in_ready) check("accept_in_ready", {31'd0, in_ready}, 32'd1);
    else if (push) begin
      e.alu = e_alu; e.d2 = d2; e.bpc = e_bpc; e.br = e_br;
      sb.push_back(e);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (sb.size() == 0) check("unexpected_out", {31'd0, out_valid}, 32'd0);
        else begin
          e = sb.pop_front();
          check("alu_out", {16'd0, ALU_out}, {16'd0, e.alu});
          check("data_2_out", {16'd0, data_2_out}, {16'd0, e.d2});
          check("branch_pc", {16'd0, branch_PC}, {16'd0, e.bpc});
          check("branch", {31'd0, branch}, {31'd0, e.br});
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_alu_out", {16'd0, ALU_out}, 32'd0);
    check("rst_branch_pc", {16'd0, branch_PC}, 32'd0);
    #16 rst = 1'b0;
    #1 check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;

    // Back-to-back ALU ops, one per cycle.
    burst_waits = 0;
    issue(OP_ADD,   16'h0005, 16'h0003, 16'h0000, 16'h0002, 0,0,0, BC_EQZ, 0,0, 16'h0008, 16'h0002, 0, 1, waited); burst_waits += waited;
    issue(OP_SUB,   16'h0005, 16'h0003, 16'h0000, 16'h0002, 0,0,0, BC_EQZ, 0,0, 16'h0002, 16'h0002, 0, 1, waited); burst_waits += waited;
    issue(OP_AND,   16'h00F0, 16'h0FF0, 16'h0000, 16'h0002, 0,0,0, BC_EQZ, 0,0, 16'h00F0, 16'h0002, 0, 1, waited); burst_waits += waited;
    issue(OP_OR,    16'h00F0, 16'h0FF0, 16'h0000, 16'h0002, 0,0,0, BC_EQZ, 0,0, 16'h0FF0, 16'h0002, 0, 1, waited); burst_waits += waited;
    issue(OP_XOR,   16'h00F0, 16'h0FF0, 16'h0000, 16'h0002, 0,0,0, BC_EQZ, 0,0, 16'h0F00, 16'h0002, 0, 1, waited); burst_waits += waited;
    issue(OP_SLL,   16'h0001, 16'h0013, 16'h0000, 16'h0002, 0,0,0, BC_EQZ, 0,0, 16'h0008, 16'h0002, 0, 1, waited); burst_waits += waited;
    issue(OP_SRL,   16'h8000, 16'h000F, 16'h0000, 16'h0002, 0,0,0, BC_EQZ, 0,0, 16'h0001, 16'h0002, 0, 1, waited); burst_waits += waited;
    issue(OP_PASSB, 16'h0000, 16'h0000, 16'h1234, 16'h0002, 0,1,0, BC_EQZ, 0,0, 16'h1234, 16'h1236, 0, 1, waited); burst_waits += waited;
    issue(OP_SEQ,   16'h0007, 16'h0007, 16'h0000, 16'h0002, 0,0,0, BC_EQZ, 0,0, 16'h0001, 16'h0002, 0, 1, waited); burst_waits += waited;
    issue(OP_SLT,   16'hFFFF, 16'h0001, 16'h0000, 16'h0002, 0,0,0, BC_EQZ, 0,0, 16'h0001, 16'h0002, 0, 1, waited); burst_waits += waited;
    issue(OP_SLT,   16'h0001, 16'hFFFF, 16'h0000, 16'h0002, 0,0,0, BC_EQZ, 0,0, 16'h0000, 16'h0002, 0, 1, waited); burst_waits += waited;
    issue(OP_PASSB, 16'h0000, 16'h0099, 16'h0000, 16'h0040, 0,0,1, BC_EQZ, 0,0, 16'h0040, 16'h0040, 0, 1, waited); burst_waits += waited;
    issue(4'hF,     16'h1111, 16'h2222, 16'h0000, 16'h0002, 0,0,0, BC_EQZ, 0,0, 16'h0000, 16'h0002, 0, 1, waited); burst_waits += waited;
    // Branch resolution.
    issue(OP_PASSB, 16'h8000, 16'h0000, 16'hFFFC, 16'h0010, 0,0,0, BC_LTZ, 1,0, 16'h0000, 16'h000C, 1, 1, waited); burst_waits += waited;
    issue(OP_PASSB, 16'h0001, 16'h0000, 16'hFFFC, 16'h0010, 0,0,0, BC_LTZ, 1,0, 16'h0000, 16'h000C, 0, 1, waited); burst_waits += waited;
    issue(OP_ADD,   16'h0100, 16'h0000, 16'h0004, 16'h0010, 1,0,0, BC_NEZ, 0,1, 16'h0100, 16'h0104, 1, 1, waited); burst_waits += waited;
    issue(OP_ADD,   16'h0000, 16'h0000, 16'h0006, 16'h0010, 0,0,0, BC_EQZ, 1,0, 16'h0000, 16'h0016, 1, 1, waited); burst_waits += waited;
    issue(OP_ADD,   16'h0003, 16'h0000, 16'h0006, 16'h0010, 0,0,0, BC_GEZ, 1,0, 16'h0003, 16'h0016, 1, 1, waited); burst_waits += waited;
    check("burst_throughput_waits", burst_waits, 32'd0);

    // Multiply; in_ready stays low for the whole iteration.
    issue(OP_MUL, 16'h0012, 16'h0034, 16'h0008, 16'h0002, 0,0,0, BC_EQZ, 0,0, MUL_EXP, 16'h000A, 0, 1, waited);
    low_cycles = 0;
    @(negedge clk);
    while (!in_ready && low_cycles < 100) begin
      low_cycles++;
      @(negedge clk);
    end
    check("mul_in_ready_low_cycles", low_cycles, MUL_LOW);
    @(posedge clk); #1;

    // Back-pressure: result must hold while out_ready is low.
    out_ready = 1'b0;
    issue(OP_ADD, 16'h0010, 16'h0020, 16'h0000, 16'h0002, 0,0,0, BC_EQZ, 0,0, 16'h0030, 16'h0002, 0, 1, waited);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_out_valid", {31'd0, out_valid}, 32'd1);
      check("stall_alu_out", {16'd0, ALU_out}, 32'h0030);
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    issue(OP_SUB, 16'h0030, 16'h0010, 16'h0000, 16'h0002, 0,0,0, BC_EQZ, 0,0, 16'h0020, 16'h0002, 0, 1, waited);
    check("drain_accept_same_cycle", waited, 32'd0);

    // Flush in the middle of a multiply.
    issue(OP_MUL, 16'h0003, 16'h0004, 16'h0000, 16'h0002, 0,0,0, BC_EQZ, 0,0, 16'h0000, 16'h0002, 0, !MUL_ON, waited);
    repeat (3) @(posedge clk);
    #1 flush = 1'b1;
    #1 check("flush_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1 flush = 1'b0;
    #1 check("flush_out_valid", {31'd0, out_valid}, 32'd0);
    check("flush_in_ready_after", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    issue(OP_ADD, 16'h0001, 16'h0001, 16'h0000, 16'h0002, 0,0,0, BC_EQZ, 0,0, 16'h0002, 16'h0002, 0, 1, waited);
    check("post_flush_accept_wait", waited, 32'd0);

    // Asynchronous reset in the middle of a multiply.
    repeat (2) @(posedge clk); #1;
    issue(OP_MUL, 16'h0012, 16'h0034, 16'h0100, 16'h0002, 0,0,0, BC_EQZ, 0,0, 16'h0000, 16'h0102, 0, !MUL_ON, waited);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check("arst_alu_out", {16'd0, ALU_out}, 32'd0);
    check("arst_data_2_out", {16'd0, data_2_out}, 32'd0);
    check("arst_branch_pc", {16'd0, branch_PC}, 32'd0);
    check("arst_branch", {31'd0, branch}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("arst_release_in_ready", {31'd0, in_ready}, 32'd1);

    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
